muler_c_bank: RTL and testbench

- Parametrised, clocked successor to the two-input Muller C-element: CH independent channels, each an NIN-input C-element.
- Adds optional input synchronisers, per-input "plus" (rise-only) masking, transition pulses and a per-channel stall watchdog.
- Sits at the boundary between asynchronous handshake signals (FIFO req/ack completion trees) and the synchronous control logic that consumes them.

---
 rtl/muler_c_bank.sv | 188 ++++++++++++++++++
 tb/tb_muler_c_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muler_c_bank.sv
// muler_c_bank: a bank of CH independent NIN-input Muller C-elements with
// optional input synchronisers, rise-only ("plus") inputs, registered
// transition pulses and a per-channel stall watchdog.
//
// The block has no handshake of its own and no FSM. Each channel's only
// state is its registered z bit and, when the watchdog is enabled, a
// saturating disagreement counter plus a sticky stall flag.
//
// Per channel c, with s the synchronised view of in_bus:
//   set = all NIN bits of s are 1
//   clr = every bit whose PLUS_MASK bit is 0 is 0
//         (this is constant 1 when every PLUS_MASK bit is 1)
//   z   <= set ? 1 : clr ? 0 : z       -- set wins over clr
// z_rise and z_fall are registered alongside z. They are high in the
// same cycle that z shows its new value.
module muler_c_bank #(
  parameter int             CH          = 2,
  parameter int             NIN         = 2,
  parameter int             SYNC_STAGES = 2,
  parameter logic [NIN-1:0] PLUS_MASK   = '0,
  parameter logic           RESET_Z     = 1'b0,
  parameter int             TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*NIN-1:0] in_bus,
  input  logic              stall_clr,
  output logic [CH-1:0]     z,
  output logic [CH-1:0]     z_rise,
  output logic [CH-1:0]     z_fall,
  output logic [CH-1:0]     stall
);

  // Inputs whose PLUS_MASK bit is 0 take part in the falling decision.
  localparam logic [NIN-1:0] FALL_MASK = ~PLUS_MASK;

  // Synchronised view of in_bus that feeds the C-element logic.
  logic [CH*NIN-1:0] s;

  // ---------------------------------------------------------------------
  // Input synchroniser: SYNC_STAGES flops per bit, or a plain wire when
  // the inputs already belong to the clk domain.
  // ---------------------------------------------------------------------
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [CH*NIN-1:0] sync_q [SYNC_STAGES];
      logic [CH*NIN-1:0] sync_d [SYNC_STAGES];

      // Shift chain: stage 0 samples in_bus, each later stage copies the
      // stage before it.
      always_comb begin
        sync_d[0] = in_bus;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_d[k] = sync_q[k-1];
        end
      end

      // Synchroniser flops. Reset clears them so that no stale input
      // survives a reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_bypass
      assign s = in_bus;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // C-element decision per channel.
  // ---------------------------------------------------------------------
  logic [CH-1:0] set_c;
  logic [CH-1:0] clr_c;

  // Compute the set and clear conditions from each channel's slice of s.
  always_comb begin
    set_c = '0;
    clr_c = '0;
    for (int c = 0; c < CH; c++) begin
      set_c[c] = &s[c*NIN +: NIN];
      clr_c[c] = ~|(s[c*NIN +: NIN] & FALL_MASK);
    end
  end

  logic [CH-1:0] z_q,    z_d;
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] fall_q, fall_d;

  // Next z: set has priority, then clr, otherwise hold. A pulse is raised
  // only when z actually changes, so rise and fall are never both high.
  always_comb begin
    z_d = z_q;
    for (int c = 0; c < CH; c++) begin
      if (set_c[c]) begin
        z_d[c] = 1'b1;
      end else if (clr_c[c]) begin
        z_d[c] = 1'b0;
      end
    end
    rise_d = z_d & ~z_q;
    fall_d = ~z_d & z_q;
  end

  // Output register for z and its transition pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q    <= {CH{RESET_Z}};
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      z_q    <= z_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign z      = z_q;
  assign z_rise = rise_q;
  assign z_fall = fall_q;

  // ---------------------------------------------------------------------
  // Stall watchdog. It counts consecutive cycles in which a channel is
  // neither set nor clear. stall_clr clears every count and every flag,
  // and wins over a timeout that lands in the same cycle.
  // ---------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int             CW    = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0]  T_MAX = CW'(TIMEOUT);

      logic [CW-1:0] cnt_q [CH];
      logic [CW-1:0] cnt_d [CH];
      logic [CH-1:0] stall_q;
      logic [CH-1:0] stall_d;

      // The counter saturates at TIMEOUT. The flag sets on the cycle the
      // counter reaches TIMEOUT and then holds until it is cleared.
      always_comb begin
        stall_d = stall_q;
        for (int c = 0; c < CH; c++) begin
          cnt_d[c] = cnt_q[c];
          if (stall_clr) begin
            cnt_d[c]   = '0;
            stall_d[c] = 1'b0;
          end else begin
            if (set_c[c] || clr_c[c]) begin
              cnt_d[c] = '0;
            end else if (cnt_q[c] != T_MAX) begin
              cnt_d[c] = cnt_q[c] + CW'(1);
            end
            if (cnt_d[c] == T_MAX) begin
              stall_d[c] = 1'b1;
            end
          end
        end
      end

      // Watchdog counters and sticky stall flags.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= '0;
          end
          stall_q <= '0;
        end else begin
          for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= cnt_d[c];
          end
          stall_q <= stall_d;
        end
      end

      assign stall = stall_q;
    end else begin : g_no_wdog
      assign stall = '0;
    end
  endgenerate

endmodule

// File: tb/tb_muler_c_bank.sv
// Bench for muler_c_bank. It builds two configurations side by side:
//   dut_a: CH=2 NIN=3 SYNC_STAGES=2 PLUS_MASK=000 TIMEOUT=8 RESET_Z=0
//   dut_b: CH=2 NIN=3 SYNC_STAGES=0 PLUS_MASK=100 TIMEOUT=4 RESET_Z=1
// A behavioural model predicts every output cycle by cycle. It delays the
// inputs through a queue, counts ones to decide set and clear, and keeps
// an unbounded run length to track disagreement. Directed steps also pin
// hand-computed literal values.
module tb_muler_c_bank;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] in_a = '0;
  logic [5:0] in_b = '0;
  logic       stall_clr = 1'b0;

  logic [1:0] z_a, rise_a, fall_a, stall_a;
  logic [1:0] z_b, rise_b, fall_b, stall_b;

  always #5 clk = ~clk;

  muler_c_bank #(.CH(2), .NIN(3), .SYNC_STAGES(2), .PLUS_MASK(3'b000),
                 .RESET_Z(1'b0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_bus(in_a), .stall_clr(stall_clr),
    .z(z_a), .z_rise(rise_a), .z_fall(fall_a), .stall(stall_a));

  muler_c_bank #(.CH(2), .NIN(3), .SYNC_STAGES(0), .PLUS_MASK(3'b100),
                 .RESET_Z(1'b1), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_bus(in_b), .stall_clr(stall_clr),
    .z(z_b), .z_rise(rise_b), .z_fall(fall_b), .stall(stall_b));

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         sync_p [2] = '{2, 0};
  logic [2:0] mask_p [2] = '{3'b000, 3'b100};
  int         tmo_p  [2] = '{8, 4};
  logic       rz_p   [2] = '{1'b0, 1'b1};

  logic [1:0] m_z [2], m_rise [2], m_fall [2], m_stall [2];
  int         m_run [2][2];
  logic [5:0] hist_a [$];
  logic [5:0] hist_b [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_z[d]     = {2{rz_p[d]}};
      m_rise[d]  = '0;
      m_fall[d]  = '0;
      m_stall[d] = '0;
      for (int c = 0; c < 2; c++) m_run[d][c] = 0;
    end
    hist_a.delete();
    hist_b.delete();
    for (int k = 0; k <= sync_p[0]; k++) hist_a.push_back(6'b0);
    for (int k = 0; k <= sync_p[1]; k++) hist_b.push_back(6'b0);
  endtask

  task automatic model_step(input int d, input logic [5:0] sv, input logic clr_in);
    for (int c = 0; c < 2; c++) begin
      logic [2:0] b;
      int ones, ones_np;
      logic hi, lo, prev, nz;
      b = sv[c*3 +: 3];
      ones = 0;
      ones_np = 0;
      for (int i = 0; i < 3; i++) begin
        if (b[i]) ones++;
        if (b[i] && !mask_p[d][i]) ones_np++;
      end
      hi   = (ones == 3);
      lo   = (ones_np == 0);
      prev = m_z[d][c];
      nz   = hi ? 1'b1 : (lo ? 1'b0 : prev);
      m_rise[d][c] = nz && !prev;
      m_fall[d][c] = !nz && prev;
      m_z[d][c]    = nz;
      if (clr_in) begin
        m_run[d][c]   = 0;
        m_stall[d][c] = 1'b0;
      end else begin
        if (hi || lo) m_run[d][c] = 0;
        else          m_run[d][c] = m_run[d][c] + 1;
        if (tmo_p[d] > 0 && m_run[d][c] >= tmo_p[d]) m_stall[d][c] = 1'b1;
      end
    end
  endtask

  // Model advances on each clock edge and resets as soon as rst_n falls.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        hist_a.push_front(in_a);
        void'(hist_a.pop_back());
        hist_b.push_front(in_b);
        void'(hist_b.pop_back());
        model_step(0, hist_a[sync_p[0]], stall_clr);
        model_step(1, hist_b[sync_p[1]], stall_clr);
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_z_a",     z_a,     m_z[0]);
      chk("model_rise_a",  rise_a,  m_rise[0]);
      chk("model_fall_a",  fall_a,  m_fall[0]);
      chk("model_stall_a", stall_a, m_stall[0]);
      chk("model_z_b",     z_b,     m_z[1]);
      chk("model_rise_b",  rise_b,  m_rise[1]);
      chk("model_fall_b",  fall_b,  m_fall[1]);
      chk("model_stall_b", stall_b, m_stall[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic [5:0] v);
    @(negedge clk);
    in_a = v;
  endtask

  task automatic drive_b(input logic [5:0] v);
    @(negedge clk);
    in_b = v;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    stall_clr = 1'b1;
    @(negedge clk);
    stall_clr = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_z_a", z_a, 2'b00);
    chk("rst_z_b", z_b, 2'b11);
    chk("rst_stall_a", stall_a, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    // dut_b sees all-zero inputs without a synchroniser: both channels fall.
    wait_edges(1);
    chk("rel_z_b", z_b, 2'b00);
    chk("rel_fall_b", fall_b, 2'b11);
    chk("rel_z_a", z_a, 2'b00);

    // ch0 000->111: z[0] rises after 3 edges, single rise pulse.
    drive_a(6'b000_111);
    wait_edges(2);
    chk("lat_early_z", z_a, 2'b00);
    wait_edges(1);
    chk("lat_z", z_a, 2'b01);
    chk("lat_rise", rise_a, 2'b01);
    chk("lat_fall", fall_a, 2'b00);
    wait_edges(1);
    chk("rise_one_cycle", rise_a, 2'b00);

    // ch0 111->011: hold, no pulses.
    drive_a(6'b000_011);
    wait_edges(5);
    chk("hold_z", z_a, 2'b01);
    chk("hold_rise", rise_a, 2'b00);
    chk("hold_fall", fall_a, 2'b00);
    // ch0 011->000: falls after 3 edges.
    drive_a(6'b000_000);
    wait_edges(2);
    chk("fall_early_z", z_a, 2'b01);
    wait_edges(1);
    chk("fall_z", z_a, 2'b00);
    chk("fall_pulse", fall_a, 2'b01);

    // ch1 at 101: stall on the 8th disagreeing cycle.
    drive_a(6'b101_000);
    wait_edges(9);
    chk("stall_before", stall_a, 2'b00);
    wait_edges(1);
    chk("stall_set", stall_a, 2'b10);
    wait_edges(10);
    chk("stall_sticky", stall_a, 2'b10);
    pulse_clr();
    chk("stall_cleared", stall_a, 2'b00);
    wait_edges(7);
    chk("stall_re_before", stall_a, 2'b00);
    wait_edges(1);
    chk("stall_re_set", stall_a, 2'b10);
    // ch1 to 111: z[1] rises; the flag stays until cleared.
    drive_a(6'b111_000);
    wait_edges(3);
    chk("ch1_z", z_a, 2'b10);
    chk("ch1_rise", rise_a, 2'b10);
    chk("ch1_stall_kept", stall_a, 2'b10);
    pulse_clr();
    wait_edges(10);
    chk("ch1_stall_gone", stall_a, 2'b00);

    // dut_b: plus mask on bit 2, latency 1.
    drive_b(6'b000_111);
    wait_edges(1);
    chk("b_set_z", z_b, 2'b01);
    chk("b_set_rise", rise_b, 2'b01);
    drive_b(6'b000_100);
    wait_edges(1);
    chk("b_plus_fall_z", z_b, 2'b00);
    chk("b_plus_fall_pulse", fall_b, 2'b01);
    drive_b(6'b000_011);
    wait_edges(1);
    chk("b_hold_z", z_b, 2'b00);
    chk("b_hold_rise", rise_b, 2'b00);
    wait_edges(2);
    chk("b_stall_before", stall_b, 2'b00);
    wait_edges(1);
    chk("b_stall_set", stall_b, 2'b01);
    drive_b(6'b111_000);
    wait_edges(1);
    chk("b_ch1_z", z_b, 2'b10);
    drive_b(6'b000_111);
    wait_edges(1);
    chk("b_both_z", z_b, 2'b01);
    chk("b_both_rise", rise_b, 2'b01);
    chk("b_both_fall", fall_b, 2'b10);

    // Reset mid-operation with z=11 and stall[1]=1 on dut_a.
    drive_a(6'b101_111);
    wait_edges(12);
    chk("pre_rst_z", z_a, 2'b11);
    chk("pre_rst_stall", stall_a, 2'b10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_z_a", z_a, 2'b00);
    chk("async_rst_stall_a", stall_a, 2'b00);
    chk("async_rst_rise_a", rise_a, 2'b00);
    chk("async_rst_z_b", z_b, 2'b11);
    chk("async_rst_stall_b", stall_b, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_edges(2);
    chk("post_rst_z_early", z_a, 2'b00);
    wait_edges(1);
    chk("post_rst_z", z_a, 2'b01);
    chk("post_rst_rise", rise_a, 2'b01);
    wait_edges(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
